// File: rtl/polar_pkg.sv
// Shared polar-code definitions: code geometry, encoder FSM states and the
// frame vector type used by both the encoder and the decoder side.
package polar_pkg;

    localparam int N          = 1024;
    localparam int LOG2N      = 10;
    localparam int BEAT_W     = 32;
    localparam int BEATS      = N / BEAT_W;
    localparam int LAYER_W    = 4;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {LOAD, ENC, OUT} enc_state_t;

    typedef logic [N-1:0] polar_vec_t;

endpackage

// File: rtl/polar_butterfly_layer.sv
// One GF(2) butterfly layer of x = u*F^(xn): every index i whose bit `layer`
// is clear absorbs its partner i + 2**layer; partners pass through unchanged.
module polar_butterfly_layer
    import polar_pkg::*;
(
    input  polar_vec_t         v,
    input  logic [LAYER_W-1:0] layer,
    output polar_vec_t         v_next
);

    polar_vec_t stage [LOG2N];

    // Shifting right by the span lines each partner up with its upper index;
    // the mask keeps only indices whose bit l is clear (low half of each block).
    for (genvar l = 0; l < LOG2N; l++) begin : g_layer
        localparam int SPAN = 1 << l;
        localparam polar_vec_t MASK = {(N / (2 * SPAN)){{SPAN{1'b0}}, {SPAN{1'b1}}}};
        assign stage[l] = v ^ ((v >> SPAN) & MASK);
    end

    always_comb begin
        v_next = v;
        for (int l = 0; l < LOG2N; l++) begin
            if (layer == LAYER_W'(l)) begin
                v_next = stage[l];
            end
        end
    end

endmodule

// File: rtl/polar_encoder_core.sv
// Polar encoder: loads an N-bit u-vector in beats, applies LOG2N butterfly
// layers (one per cycle, span 1 upward), then streams x out in beats.
module polar_encoder_core
    import polar_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BEAT_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BEAT_W-1:0]  out_data,
    output logic               out_last,
    output logic [LAYER_W-1:0] cur_layer,
    output logic               busy
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT  = BEAT_CNT_W'(BEATS - 1);
    localparam logic [LAYER_W-1:0]    LAST_LAYER = LAYER_W'(LOG2N - 1);

    enc_state_t              state, state_d;
    logic [BEAT_CNT_W-1:0]   beat_cnt, beat_cnt_d;
    logic [LAYER_W-1:0]      layer, layer_d;
    polar_vec_t              frame_buf;
    polar_vec_t              layer_out;
    logic [BEAT_W-1:0]       beat_view [BEATS];
    logic                    in_fire;
    logic                    out_fire;

    // Valid/ready: a beat transfers on a rising edge where valid and ready are
    // both high; the source holds valid and data steady until that edge.
    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == OUT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != LOAD);
    assign cur_layer = (state == ENC) ? layer : '0;
    assign out_last  = out_valid && (beat_cnt == LAST_BEAT);
    assign out_data  = out_valid ? beat_view[beat_cnt] : '0;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_view[b] = frame_buf[b*BEAT_W +: BEAT_W];
    end

    polar_butterfly_layer u_layer (
        .v      (frame_buf),
        .layer  (layer),
        .v_next (layer_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            beat_cnt <= '0;
            layer    <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
            layer    <= layer_d;
        end
    end

    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        layer_d    = layer;
        case (state)
            LOAD: begin
                if (in_fire) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        layer_d    = '0;
                        state_d    = ENC;
                    end else begin
                        beat_cnt_d = beat_cnt + 1'b1;
                    end
                end
            end
            ENC: begin
                if (layer == LAST_LAYER) begin
                    state_d = OUT;
                end else begin
                    layer_d = layer + 1'b1;
                end
            end
            OUT: begin
                if (out_fire) begin
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = LOAD;
                    end else begin
                        beat_cnt_d = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // The frame buffer carries no reset; a new frame overwrites every beat.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt == BEAT_CNT_W'(b)) begin
                    frame_buf[b*BEAT_W +: BEAT_W] <= in_data;
                end
            end
        end else if (state == ENC) begin
            frame_buf <= layer_out;
        end
    end

endmodule

// File: tb/tb_polar_encoder_core.sv
// Scoreboard bench for polar_encoder_core: random and directed u-vectors are
// checked beat by beat against x_i = XOR of u_j over all supersets j of i.
module tb_polar_encoder_core;
    import polar_pkg::*;

    localparam int W       = BEAT_W + 1;
    localparam int TIMEOUT = 2000;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BEAT_W-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BEAT_W-1:0]  out_data;
    logic               out_last;
    logic [LAYER_W-1:0] cur_layer;
    logic               busy;

    logic [W-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  stall_en = 0;
    bit  tb_last = 0;
    int  mon_beat_idx = 0;

    polar_encoder_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .cur_layer (cur_layer),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: x_i = XOR of u_j over every j that contains all bits of i
    function automatic polar_vec_t golden(input polar_vec_t u);
        polar_vec_t x;
        for (int i = 0; i < N; i++) begin
            logic acc;
            acc = 1'b0;
            for (int j = i; j < N; j = (j + 1) | i) acc ^= u[j];
            x[i] = acc;
        end
        return x;
    endfunction

    // driver: push expected beats, then feed u beats with optional idle gaps
    task automatic send_frame(input polar_vec_t u, input int gap_pct);
        polar_vec_t x;
        x = golden(u);
        for (int b = 0; b < BEATS; b++)
            exp_q.push_back({(b == BEATS - 1), x[b*BEAT_W +: BEAT_W]});
        for (int b = 0; b < BEATS; b++) begin
            bit took;
            int guard;
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 0;
                @(posedge clk); #1;
            end
            in_valid = 1;
            in_data  = u[b*BEAT_W +: BEAT_W];
            tb_last  = (b == BEATS - 1);
            took  = 0;
            guard = 0;
            while (!took) begin
                @(negedge clk);
                took = in_ready;
                @(posedge clk); #1;
                guard++;
                if (!took && guard > TIMEOUT) begin
                    check("in_ready_timeout", 0, 1);
                    in_valid = 0;
                    tb_last  = 0;
                    return;
                end
            end
        end
        in_valid = 0;
        tb_last  = 0;
    endtask

    task automatic rand_vec(output polar_vec_t u);
        for (int w = 0; w < N / 32; w++) u[w*32 +: 32] = $urandom();
    endtask

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk); #1;
            out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // monitor / scoreboard
    int            acc_edge = -1;
    bit            held = 0;
    logic [W-1:0]  held_val;
    bit            expect_idle = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_edge     = -1;
            held         = 0;
            expect_idle  = 0;
            mon_beat_idx = 0;
        end else begin
            int d;
            check("in_ready_vs_busy", in_ready, !busy);
            if (expect_idle) begin
                check("in_ready_after_last", in_ready, 1);
                expect_idle = 0;
            end
            d = cyc - acc_edge;
            if (acc_edge >= 0 && d >= 0 && d < LOG2N) begin
                check("enc_cur_layer", cur_layer, d);
                check("enc_busy", busy, 1);
                check("enc_out_valid", out_valid, 0);
            end else begin
                check("cur_layer_idle", cur_layer, 0);
                if (acc_edge >= 0 && d == LOG2N) begin
                    check("latency_out_valid", out_valid, 1);
                    acc_edge = -1;
                end
            end
            if (!out_valid) begin
                check("out_data_zero", {out_last, out_data}, 0);
                held = 0;
            end else begin
                if (held) check("stall_hold", {out_last, out_data}, held_val);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {out_last, out_data}, 0);
                    end else begin
                        check("out_beat", {out_last, out_data}, exp_q.pop_front());
                    end
                    mon_beat_idx++;
                    if (out_last) begin
                        mon_beat_idx = 0;
                        expect_idle  = 1;
                    end
                    held = 0;
                end else begin
                    held     = 1;
                    held_val = {out_last, out_data};
                end
            end
            if (in_valid && in_ready && tb_last) acc_edge = cyc + 1;
        end
    end

    task automatic check_after_reset();
        @(posedge clk); #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cur_layer", cur_layer, 0);
        check("rst_busy", busy, 0);
        rst = 0;
        @(posedge clk); #2;
        check("rst_release_in_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < TIMEOUT) begin
            @(posedge clk);
            guard++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        polar_vec_t u;
        int guard;
        rst = 1; in_valid = 0; in_data = '0;
        repeat (3) @(posedge clk);
        check_after_reset();

        // directed patterns, no stalls
        u = '0; u[N-1] = 1'b1; send_frame(u, 0);
        u = '0; u[0]   = 1'b1; send_frame(u, 0);
        u = '0; u[1]   = 1'b1; send_frame(u, 0);
        u = '0; u[5]   = 1'b1; send_frame(u, 0);
        drain();

        // random frames with input gaps and output stalls
        stall_en = 1;
        for (int f = 0; f < 4; f++) begin
            rand_vec(u);
            send_frame(u, 25);
        end
        drain();

        // back-to-back frames, everything always ready
        stall_en = 0;
        for (int f = 0; f < 2; f++) begin
            rand_vec(u);
            send_frame(u, 0);
        end
        drain();

        // reset in the middle of ENC at layer 4
        rand_vec(u);
        send_frame(u, 0);
        #1;
        guard = 0;
        while (!(busy && !out_valid && cur_layer == 4) && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        check("reach_layer4", cur_layer, 4);
        rst = 1;
        exp_q.delete();
        check_after_reset();

        // reset in the middle of OUT at beat 7
        stall_en = 1;
        rand_vec(u);
        send_frame(u, 10);
        #1;
        guard = 0;
        while (!(out_valid && mon_beat_idx == 7) && guard < 400) begin
            @(posedge clk); #2;
            guard++;
        end
        check("reach_beat7", mon_beat_idx, 7);
        rst = 1;
        exp_q.delete();
        check_after_reset();

        // fresh frame after the aborts
        rand_vec(u);
        send_frame(u, 20);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
